top6_result_collector: RTL and testbench
========================================

// Module: top6_result_collector
// PURPOSE
//  Receive end of the top-6 selector output stream. Captures the serial 16-bit
//  result words {Value[7:0], Index[4:0], GroupNumber[2:0]}, one per valid cycle,
//  into a 6-entry result table. Checks group sequence (0..5) and non-increasing
//  value order. Flags a complete frame, then exposes the table on a registered
//  read port for downstream logic.
// PARAMETERS
//  VALUE_W  8  width of Value field
//  INDEX_W  5  width of Index field
//  GROUP_W  3  width of GroupNumber field
//  DEPTH    6  entries per frame; groups 0..DEPTH-1 are legal
// PORTS
//  Clk       in   1   system clock, rising edge
//  Reset     in   1   asynchronous, active-low reset
//  DataIn    in   16  {Value, Index, GroupNumber} word from the selector
//  DataValid in   1   DataIn is sampled on this cycle's rising edge
//  Clear     in   1   synchronous frame abort/clear
//  RdAddr    in   3   table entry to read, 0..5
//  RdData    out  13  {Value, Index} of entry RdAddr, registered
//  Done      out  1   level: full frame captured, table stable
//  GroupErr  out  1   sticky: out-of-sequence or illegal group seen in frame
//  OrderErr  out  1   sticky: Value greater than previous entry's Value
//  FrameCnt  out  8   count of completed frames, wraps 255->0
// BEHAVIOUR
//  Reset (Reset=0, async): FSM=IDLE. Table entries, RdData, Done, GroupErr,
//   OrderErr and FrameCnt all 0. Expected group = 0. Last value = 0.
//  FSM states: IDLE, COLLECT, DONE.
//  Priority within one edge: Reset > Clear > DataValid.
//  Clear=1: go to IDLE. Done, GroupErr and OrderErr go to 0. Table entries and
//   FrameCnt are kept. Any DataValid word on the same cycle is dropped.
//  IDLE: DataValid with Group=0 -> store entry 0, last value=Value, expected
//   group=1, go to COLLECT. DataValid with Group!=0 -> word is dropped,
//   GroupErr=1, state stays IDLE.
//  COLLECT, DataValid:
//   - Group=0: restart the frame. Store entry 0, clear both error flags,
//     expected group=1.
//   - Group=expected (<DEPTH): store the word at entry Group. If Value >
//     last value, set OrderErr (ties are legal). Then last value=Value and
//     expected group increments.
//   - Any other group (skip, repeat, or 6/7): GroupErr=1 and the word is not
//     stored. Expected group is unchanged.
//   - On storing group DEPTH-1: go to DONE. Done=1 from the next edge.
//     FrameCnt+1 on the same edge.
//  DONE: Done stays 1 and the table is frozen. A DataValid word with Group=0
//   starts a new frame, same as IDLE: Done=0 on that edge and the error flags
//   clear. Other valid words are dropped and GroupErr is not set.
//  No DataValid: no state change, in any state.
//  Read port: RdData <= table[RdAddr] on every edge, so latency is 1 cycle.
//   RdAddr>=DEPTH -> RdData=0. A read of an entry written on the same edge
//   returns the old contents.
//  Widths: the Value compare is unsigned VALUE_W bits. FrameCnt wraps
//   modulo 256.
// TESTING
//  1 Reset low, then stream 6 valid words (245,0,g0)(245,2,g1)(243,15,g2)
//    (217,7,g3)(204,3,g4)(202,5,g5) -> Done=1 one cycle after g5,
//    FrameCnt=1, no errors. RdAddr=0 -> RdData={245,0} next cycle;
//    RdAddr=5 -> {202,5}; RdAddr=7 -> 0.
//  2 Frame with g2 value 250 (> 245) -> OrderErr=1 and Done=1. Tie 245/245
//    at g0/g1 alone -> OrderErr stays 0.
//  3 Sequence g0,g1,g3 -> GroupErr=1 and g3 dropped. Then g2..g5 -> Done=1
//    with GroupErr still 1. Group 7 in IDLE -> GroupErr=1, state IDLE.
//  4 DataValid idle for 10 cycles mid-frame after g2 -> no change; then g3..g5
//    -> Done=1. A g0 word in COLLECT after g3 -> restart, errors cleared,
//    6 more words needed.
//  5 Clear and DataValid(g0) on the same cycle in DONE -> IDLE, Done=0,
//    word dropped, table kept. Reset pulsed low mid-frame -> all outputs
//    0 immediately, without waiting for a clock.
//  6 256 back-to-back good frames -> FrameCnt wraps to 0. In DONE a g3
//    word -> ignored, GroupErr stays 0.

Source files
------------

// File: rtl/top6_result_collector_if.sv
// top6_result_collector_if: selector result stream in, table read port and status out
interface top6_result_collector_if #(
    parameter int VALUE_W = 8,
    parameter int INDEX_W = 5,
    parameter int GROUP_W = 3
);
    logic [VALUE_W+INDEX_W+GROUP_W-1:0] DataIn;
    logic                               DataValid;
    logic                               Clear;
    logic [GROUP_W-1:0]                 RdAddr;
    logic [VALUE_W+INDEX_W-1:0]         RdData;
    logic                               Done;
    logic                               GroupErr;
    logic                               OrderErr;
    logic [7:0]                         FrameCnt;

    modport master (
        output DataIn, DataValid, Clear, RdAddr,
        input  RdData, Done, GroupErr, OrderErr, FrameCnt
    );

    modport slave (
        input  DataIn, DataValid, Clear, RdAddr,
        output RdData, Done, GroupErr, OrderErr, FrameCnt
    );
endinterface

// File: rtl/top6_result_collector.sv
// top6_result_collector: captures one top-6 frame into a table, checks group order and value order
module top6_result_collector #(
    parameter int VALUE_W = 8,
    parameter int INDEX_W = 5,
    parameter int GROUP_W = 3,
    parameter int DEPTH   = 6
) (
    input logic                  Clk,
    input logic                  Reset,
    top6_result_collector_if.slave bus
);
    localparam int ENTRY_W = VALUE_W + INDEX_W;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   tbl_q [DEPTH];
    logic [ENTRY_W-1:0]   tbl_d [DEPTH];
    logic [ENTRY_W-1:0]   rd_data_q, rd_data_d;
    logic                 done_q, done_d;
    logic                 group_err_q, group_err_d;
    logic                 order_err_q, order_err_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic [GROUP_W-1:0]   exp_q, exp_d;
    logic [VALUE_W-1:0]   last_q, last_d;

    logic [VALUE_W-1:0]   in_value;
    logic [ENTRY_W-1:0]   in_entry;
    logic [GROUP_W-1:0]   in_group;

    assign in_value = bus.DataIn[GROUP_W+ENTRY_W-1 -: VALUE_W];
    assign in_entry = bus.DataIn[GROUP_W+ENTRY_W-1 -: ENTRY_W];
    assign in_group = bus.DataIn[GROUP_W-1:0];

    assign bus.RdData   = rd_data_q;
    assign bus.Done     = done_q;
    assign bus.GroupErr = group_err_q;
    assign bus.OrderErr = order_err_q;
    assign bus.FrameCnt = frame_cnt_q;

    // Next-state: Clear beats DataValid; group 0 always (re)starts a frame,
    // the expected group extends it, anything else is an error outside DONE
    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        done_d      = done_q;
        group_err_d = group_err_q;
        order_err_d = order_err_q;
        frame_cnt_d = frame_cnt_q;
        exp_d       = exp_q;
        last_d      = last_q;
        rd_data_d   = (bus.RdAddr < GROUP_W'(DEPTH)) ? tbl_q[bus.RdAddr] : '0;
        if (bus.Clear) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            group_err_d = 1'b0;
            order_err_d = 1'b0;
        end else if (bus.DataValid) begin
            if (in_group == '0) begin
                tbl_d[0]    = in_entry;
                last_d      = in_value;
                exp_d       = GROUP_W'(1);
                state_d     = COLLECT;
                done_d      = 1'b0;
                group_err_d = 1'b0;
                order_err_d = 1'b0;
            end else if (state_q == COLLECT && in_group == exp_q) begin
                tbl_d[in_group] = in_entry;
                order_err_d     = order_err_q | (in_value > last_q);
                last_d          = in_value;
                exp_d           = exp_q + GROUP_W'(1);
                if (in_group == GROUP_W'(DEPTH - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end else if (state_q != DONE) begin
                group_err_d = 1'b1;
            end
        end
    end

    // State and registered outputs, async active-low reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            tbl_q       <= '{default: '0};
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            group_err_q <= 1'b0;
            order_err_q <= 1'b0;
            frame_cnt_q <= '0;
            exp_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            group_err_q <= group_err_d;
            order_err_q <= order_err_d;
            frame_cnt_q <= frame_cnt_d;
            exp_q       <= exp_d;
            last_q      <= last_d;
        end
    end
endmodule

// File: tb/tb_top6_result_collector.sv
// tb_top6_result_collector: directed scenarios plus random stream against a frame-level model
module tb_top6_result_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    top6_result_collector_if bus ();

    top6_result_collector dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    // Reference model: the frame is described by how many entries it holds
    logic [12:0] m_tbl [6];
    int          m_n;
    int          m_last;
    logic        m_gerr;
    logic        m_oerr;
    logic [7:0]  m_fc;
    logic [12:0] m_rd;

    function automatic logic [15:0] w(input int v, input int i, input int g);
        return {8'(v), 5'(i), 3'(g)};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 6; k++) m_tbl[k] = '0;
        m_n = 0;
        m_last = 0;
        m_gerr = 1'b0;
        m_oerr = 1'b0;
        m_fc = '0;
        m_rd = '0;
    endfunction

    function automatic void model(input logic c, input logic v, input logic [15:0] d, input logic [2:0] a);
        int g;
        int val;
        g = int'(d[2:0]);
        val = int'(d[15:8]);
        m_rd = (a < 3'd6) ? m_tbl[a] : 13'd0;
        if (c) begin
            m_n = 0;
            m_gerr = 1'b0;
            m_oerr = 1'b0;
        end else if (v) begin
            if (g == 0) begin
                m_tbl[0] = d[15:3];
                m_n = 1;
                m_last = val;
                m_gerr = 1'b0;
                m_oerr = 1'b0;
            end else if (m_n == 6) begin
            end else if (m_n > 0 && g == m_n) begin
                m_tbl[g] = d[15:3];
                if (val > m_last) m_oerr = 1'b1;
                m_last = val;
                m_n++;
                if (m_n == 6) m_fc = m_fc + 8'd1;
            end else begin
                m_gerr = 1'b1;
            end
        end
    endfunction

    task automatic step(input logic c, input logic v, input logic [15:0] d, input logic [2:0] a);
        @(negedge clk);
        bus.Clear = c;
        bus.DataValid = v;
        bus.DataIn = d;
        bus.RdAddr = a;
        @(posedge clk);
        model(c, v, d, a);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        total += 5;
        if (bus.RdData !== 13'd0) begin bad++; $display("FAIL reset_rddata: got %h want 0", bus.RdData); end
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.Done); end
        if (bus.GroupErr !== 1'b0) begin bad++; $display("FAIL reset_grouperr: got %b want 0", bus.GroupErr); end
        if (bus.OrderErr !== 1'b0) begin bad++; $display("FAIL reset_ordererr: got %b want 0", bus.OrderErr); end
        if (bus.FrameCnt !== 8'd0) begin bad++; $display("FAIL reset_framecnt: got %0d want 0", bus.FrameCnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        step(0, 1, w(245, 0, 0), 0);
        step(0, 1, w(245, 2, 1), 0);
        step(0, 1, w(243, 15, 2), 0);
        step(0, 1, w(217, 7, 3), 0);
        step(0, 1, w(204, 3, 4), 0);
        total++;
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL frame_done_early: got %b want 0", bus.Done); end
        step(0, 1, w(202, 5, 5), 0);
        total += 4;
        if (bus.Done !== 1'b1) begin bad++; $display("FAIL frame_done: got %b want 1", bus.Done); end
        if (bus.FrameCnt !== 8'd1) begin bad++; $display("FAIL frame_cnt: got %0d want 1", bus.FrameCnt); end
        if (bus.GroupErr !== 1'b0) begin bad++; $display("FAIL frame_grouperr: got %b want 0", bus.GroupErr); end
        if (bus.OrderErr !== 1'b0) begin bad++; $display("FAIL frame_ordererr: got %b want 0", bus.OrderErr); end
        step(0, 0, 16'd0, 3'd0);
        total++;
        if (bus.RdData !== {8'd245, 5'd0}) begin bad++; $display("FAIL read_0: got %h want %h", bus.RdData, {8'd245, 5'd0}); end
        step(0, 0, 16'd0, 3'd5);
        total++;
        if (bus.RdData !== {8'd202, 5'd5}) begin bad++; $display("FAIL read_5: got %h want %h", bus.RdData, {8'd202, 5'd5}); end
        step(0, 0, 16'd0, 3'd7);
        total++;
        if (bus.RdData !== 13'd0) begin bad++; $display("FAIL read_7: got %h want 0", bus.RdData); end
    endtask

    task automatic test_order();
        step(0, 1, w(245, 1, 0), 0);
        step(0, 1, w(245, 2, 1), 0);
        total++;
        if (bus.OrderErr !== 1'b0) begin bad++; $display("FAIL order_tie: got %b want 0", bus.OrderErr); end
        step(0, 1, w(250, 3, 2), 0);
        total++;
        if (bus.OrderErr !== 1'b1) begin bad++; $display("FAIL order_rise: got %b want 1", bus.OrderErr); end
        step(0, 1, w(200, 4, 3), 0);
        step(0, 1, w(190, 5, 4), 0);
        step(0, 1, w(180, 6, 5), 0);
        total += 3;
        if (bus.Done !== 1'b1) begin bad++; $display("FAIL order_done: got %b want 1", bus.Done); end
        if (bus.OrderErr !== 1'b1) begin bad++; $display("FAIL order_sticky: got %b want 1", bus.OrderErr); end
        if (bus.FrameCnt !== 8'd2) begin bad++; $display("FAIL order_cnt: got %0d want 2", bus.FrameCnt); end
    endtask

    task automatic test_group();
        step(0, 1, w(160, 0, 0), 0);
        step(0, 1, w(155, 1, 1), 0);
        step(0, 1, w(150, 9, 3), 0);
        total++;
        if (bus.GroupErr !== 1'b1) begin bad++; $display("FAIL group_skip: got %b want 1", bus.GroupErr); end
        step(0, 1, w(152, 2, 2), 0);
        step(0, 1, w(140, 3, 3), 0);
        step(0, 1, w(130, 4, 4), 0);
        step(0, 1, w(120, 5, 5), 3);
        total += 2;
        if (bus.Done !== 1'b1) begin bad++; $display("FAIL group_done: got %b want 1", bus.Done); end
        if (bus.GroupErr !== 1'b1) begin bad++; $display("FAIL group_sticky: got %b want 1", bus.GroupErr); end
        step(0, 0, 16'd0, 3'd3);
        total++;
        if (bus.RdData !== {8'd140, 5'd3}) begin bad++; $display("FAIL group_dropped: got %h want %h", bus.RdData, {8'd140, 5'd3}); end
        step(1, 0, 16'd0, 3'd0);
        step(0, 1, w(77, 7, 7), 0);
        total += 2;
        if (bus.GroupErr !== 1'b1) begin bad++; $display("FAIL group_idle7: got %b want 1", bus.GroupErr); end
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL group_idle_done: got %b want 0", bus.Done); end
        step(0, 1, w(99, 9, 1), 0);
        step(0, 0, 16'd0, 3'd1);
        total++;
        if (bus.RdData !== {8'd155, 5'd1}) begin bad++; $display("FAIL group_idle_drop: got %h want %h", bus.RdData, {8'd155, 5'd1}); end
    endtask

    task automatic test_gap_restart();
        step(0, 1, w(200, 0, 0), 0);
        step(0, 1, w(210, 1, 1), 0);
        step(0, 1, w(190, 2, 2), 0);
        repeat (10) step(0, 0, w(5, 5, 3), 0);
        total += 2;
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL gap_done: got %b want 0", bus.Done); end
        if (bus.OrderErr !== 1'b1) begin bad++; $display("FAIL gap_ordererr: got %b want 1", bus.OrderErr); end
        step(0, 1, w(180, 3, 3), 0);
        step(0, 1, w(170, 4, 4), 0);
        step(0, 1, w(160, 5, 5), 0);
        total++;
        if (bus.Done !== 1'b1) begin bad++; $display("FAIL gap_resume: got %b want 1", bus.Done); end
        step(0, 1, w(100, 0, 0), 0);
        step(0, 1, w(120, 1, 1), 0);
        step(0, 1, w(110, 2, 2), 0);
        step(0, 1, w(105, 3, 3), 0);
        step(0, 1, w(90, 9, 0), 0);
        total += 2;
        if (bus.OrderErr !== 1'b0) begin bad++; $display("FAIL restart_clear: got %b want 0", bus.OrderErr); end
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL restart_done: got %b want 0", bus.Done); end
        for (int g = 1; g < 5; g++) step(0, 1, w(90 - g, g, g), 0);
        total++;
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL restart_need6: got %b want 0", bus.Done); end
        step(0, 1, w(80, 5, 5), 0);
        total += 2;
        if (bus.Done !== 1'b1) begin bad++; $display("FAIL restart_done6: got %b want 1", bus.Done); end
        if (bus.FrameCnt !== 8'd5) begin bad++; $display("FAIL restart_cnt: got %0d want 5", bus.FrameCnt); end
    endtask

    task automatic test_clear_reset();
        step(1, 1, w(11, 1, 0), 0);
        total++;
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL clear_done: got %b want 0", bus.Done); end
        step(0, 0, 16'd0, 3'd0);
        total += 2;
        if (bus.RdData !== {8'd90, 5'd9}) begin bad++; $display("FAIL clear_kept: got %h want %h", bus.RdData, {8'd90, 5'd9}); end
        if (bus.FrameCnt !== 8'd5) begin bad++; $display("FAIL clear_cnt: got %0d want 5", bus.FrameCnt); end
        step(0, 1, w(60, 1, 0), 0);
        step(0, 1, w(70, 2, 1), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total += 4;
        if (bus.RdData !== 13'd0) begin bad++; $display("FAIL areset_rddata: got %h want 0", bus.RdData); end
        if (bus.OrderErr !== 1'b0) begin bad++; $display("FAIL areset_ordererr: got %b want 0", bus.OrderErr); end
        if (bus.FrameCnt !== 8'd0) begin bad++; $display("FAIL areset_cnt: got %0d want 0", bus.FrameCnt); end
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL areset_done: got %b want 0", bus.Done); end
        bus.DataValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int f = 1; f <= 256; f++) begin
            for (int g = 0; g < 6; g++) step(0, 1, w(100, g, g), 0);
            if (f == 255) begin
                total++;
                if (bus.FrameCnt !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", bus.FrameCnt); end
            end
        end
        total += 2;
        if (bus.FrameCnt !== 8'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", bus.FrameCnt); end
        if (bus.Done !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b want 1", bus.Done); end
        step(0, 1, w(50, 3, 3), 0);
        total += 2;
        if (bus.GroupErr !== 1'b0) begin bad++; $display("FAIL done_ignore_err: got %b want 0", bus.GroupErr); end
        if (bus.Done !== 1'b1) begin bad++; $display("FAIL done_ignore_done: got %b want 1", bus.Done); end
    endtask

    task automatic test_random();
        logic        c;
        logic        v;
        logic [15:0] d;
        int          g;
        int          val;
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) g = (m_n == 6) ? 0 : m_n;
            else g = $urandom_range(0, 7);
            if (g == 0) val = $urandom_range(120, 255);
            else if ($urandom_range(0, 7) == 0) val = $urandom_range(0, 255);
            else val = (m_last > 20) ? m_last - $urandom_range(0, 20) : m_last;
            d = w(val, $urandom_range(0, 31), g);
            step(c, v, d, 3'($urandom_range(0, 7)));
            total += 5;
            if (bus.RdData !== m_rd) begin bad++; $display("FAIL rand_rddata @%0d: got %h want %h", i, bus.RdData, m_rd); end
            if (bus.Done !== (m_n == 6)) begin bad++; $display("FAIL rand_done @%0d: got %b want %b", i, bus.Done, m_n == 6); end
            if (bus.GroupErr !== m_gerr) begin bad++; $display("FAIL rand_grouperr @%0d: got %b want %b", i, bus.GroupErr, m_gerr); end
            if (bus.OrderErr !== m_oerr) begin bad++; $display("FAIL rand_ordererr @%0d: got %b want %b", i, bus.OrderErr, m_oerr); end
            if (bus.FrameCnt !== m_fc) begin bad++; $display("FAIL rand_framecnt @%0d: got %0d want %0d", i, bus.FrameCnt, m_fc); end
        end
    endtask

    initial begin
        bus.DataIn = '0;
        bus.DataValid = 1'b0;
        bus.Clear = 1'b0;
        bus.RdAddr = '0;
        test_reset();
        test_frame();
        test_order();
        test_group();
        test_gap_restart();
        test_clear_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
